dmem_line_responder: RTL and testbench
======================================

// Module: dmem_line_responder
// PURPOSE
//   Backing data memory on the far side of the D-cache refill/write-back interface.
//   Accepts one 256-bit line request (read = refill, write = write-back), waits a fixed
//   access latency, then completes it with a single-cycle ack_o. This is the responder the
//   cache controller initiates against; the cache data SRAM stays local to the cache.
// PARAMETERS
//   LATENCY     10   cycles from request acceptance to ack_o (legal range 1..255)
//   DEPTH_LOG2  9    log2 of line count (512 lines x 32 B = 16 KB)
//   LINE_BITS   256  line width in bits; fixed to match the cache line
// PORTS
//   clk_i     in   1          single clock, all state on posedge
//   rst_i     in   1          synchronous, active-high reset
//   enable_i  in   1          request valid; held high by the initiator until ack_o
//   write_i   in   1          1 = line write (write-back), 0 = line read (refill)
//   addr_i    in   32         byte address; line index = addr_i[DEPTH_LOG2+4:5]
//   data_i    in   LINE_BITS  write line data
//   ack_o     out  1          one-cycle completion pulse
//   data_o    out  LINE_BITS  read line data, valid in the ack_o cycle, held afterwards
// BEHAVIOUR
//   Reset: state=IDLE, ack_o=0, data_o=0, latency counter=0; array contents not cleared.
//   FSM states: IDLE, WAIT, ACK.
//   - IDLE: enable_i=1 at edge T -> capture line index, write_i, data_i into request
//     registers; counter<=LATENCY-1; go WAIT (LATENCY=1: go straight to ACK).
//   - WAIT: counter decrements each cycle; at counter==1 go ACK. enable_i/addr_i/data_i
//     changes ignored -- only the captured request is used.
//   - ACK: ack_o=1 for exactly this cycle, first ack cycle = T+LATENCY.
//     Write: array[idx]<=captured data at the edge ending the ACK cycle; data_o unchanged.
//     Read: data_o<=array[idx] registered so it is valid during ACK; held until the next
//     read ack. Unconditionally return to IDLE.
//   - enable_i high during ACK is not a new request; next acceptance no earlier than the
//     IDLE cycle after ACK (one-cycle bubble, request-to-request minimum LATENCY+2).
//   Addressing: addr_i[4:0] ignored (line aligned); addr_i[31:DEPTH_LOG2+5] ignored, so
//     addresses alias modulo 2^(DEPTH_LOG2+5) bytes.
//   Read after write to same line: read issued after the write ack returns the new data.
//   Reset mid-operation (WAIT or ACK): request dropped, no ack_o, pending write NOT
//     committed, state IDLE next cycle.
//   Counter width: $clog2(LATENCY+1); no wrap, LATENCY bounded by parameter check.
//   enable_i low in IDLE: no state change, ack_o=0, data_o held.
// STRUCTURE
//   Package dmem_pkg: state encoding (IDLE/WAIT/ACK), LINE_BITS=256, LINE_OFFSET_BITS=5,
//     shared with the cache controller so both ends agree on line geometry.
//   Sub-module dmem_line_array: 2^DEPTH_LOG2 x LINE_BITS storage, synchronous write port,
//     registered read port; instantiated once. FSM, counter, request regs stay top-level.
// TESTING
//   1 Reset then idle 20 cycles, enable_i=0 -> ack_o never 1, data_o==0.
//   2 Write addr 0x0000_0040 data {8{32'hDEAD_BEEF}} at cycle T -> ack_o only at T+10;
//     then read 0x0000_0040 -> ack_o after 10 cycles, data_o=={8{32'hDEAD_BEEF}}.
//   3 Alias: write 0x0000_0043, read 0x0000_4040 (DEPTH_LOG2=9) -> same line returned.
//   4 Change addr_i/data_i every cycle during WAIT -> captured request honoured, ack at T+10.
//   5 Assert rst_i at T+5 of a write to 0x80 -> no ack_o; later read of 0x80 returns old data.
//   6 LATENCY=1 build: back-to-back requests with enable_i held -> acks at T+1, T+4, T+7.

Source files
------------

// File: rtl/dmem_pkg.sv
// Line geometry and FSM encoding shared between the D-cache controller and the
// backing line memory, so both ends agree on how an address maps to a line.
package dmem_pkg;

    localparam int unsigned LINE_BITS        = 256;
    localparam int unsigned LINE_OFFSET_BITS = 5;
    localparam int unsigned ADDR_BITS        = 32;

    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } dmem_state_e;

    // Line index of a byte address; upper bits beyond the array depth alias.
    function automatic logic [ADDR_BITS-1:0] line_index(input logic [ADDR_BITS-1:0] addr,
                                                        input int unsigned depth_log2);
        logic [ADDR_BITS-1:0] mask;
        mask = (ADDR_BITS'(1) << depth_log2) - ADDR_BITS'(1);
        return (addr >> LINE_OFFSET_BITS) & mask;
    endfunction

endpackage

// File: rtl/dmem_line_array.sv
// Line storage: 2^DEPTH_LOG2 lines, synchronous write port and a registered read
// port whose output holds its value until the next read.
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  line_t                 wdata_i,
    output line_t                 rdata_o
);

    localparam int unsigned Lines = 2 ** DEPTH_LOG2;

    line_t mem_q [Lines];
    line_t rdata_q;

    // Contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_line_responder.sv
// Backing data memory behind the D-cache refill/write-back port: accepts one line
// request, waits a fixed latency, then completes it with a one-cycle ack_o.
module dmem_line_responder
    import dmem_pkg::*;
#(
    parameter int unsigned LATENCY    = 10,
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  line_t                data_i,
    output logic                 ack_o,
    output line_t                data_o
);

    localparam int unsigned CntW = $clog2(LATENCY + 1);
    localparam int unsigned IdxLo = LINE_OFFSET_BITS;
    localparam int unsigned IdxHi = DEPTH_LOG2 + LINE_OFFSET_BITS - 1;

    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
        $error("dmem_line_responder: LATENCY must be within 1..255");
    end

    dmem_state_e           state_q;
    logic [CntW-1:0]       cnt_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  write_q;
    line_t                 wdata_q;
    logic                  array_we;
    logic                  array_re;

    logic unused_addr;
    assign unused_addr = ^{addr_i[ADDR_BITS-1:IdxHi+1], addr_i[IdxLo-1:0]};

    // ack_o is raised on the edge leaving StAck, so the cycle it is high is always
    // spent in StIdle; refusing requests while it is high gives the one-cycle bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            ack_o   <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable_i && !ack_o) begin
                        idx_q   <= addr_i[IdxHi:IdxLo];
                        write_q <= write_i;
                        wdata_q <= data_i;
                        if (LATENCY == 1) begin
                            state_q <= StAck;
                        end else begin
                            cnt_q   <= CntW'(LATENCY - 1);
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StAck;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StAck: begin
                    ack_o   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Array access happens on the same edge that raises ack_o; a reset on that
    // edge drops the request, including any pending write.
    assign array_we = (state_q == StAck) && write_q && !rst_i;
    assign array_re = (state_q == StAck) && !write_q && !rst_i;

    dmem_line_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (array_we),
        .re_i   (array_re),
        .addr_i (idx_q),
        .wdata_i(wdata_q),
        .rdata_o(data_o)
    );

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed and randomized checks of the line responder against a line-array model.
module tb_dmem_line_responder;

    localparam int Lat   = 10;
    localparam int DLog  = 9;
    localparam int Lines = 512;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, wr, ack;
    logic [31:0]  addr;
    logic [255:0] din, dout;
    logic         en1, wr1, ack1;
    logic [31:0]  addr1;
    logic [255:0] din1, dout1;

    int n_vec = 0;
    int n_err = 0;

    logic [255:0] model [Lines];
    bit           known [Lines];
    logic [255:0] last_rd;
    int           idx_q[$];

    always #5 clk = ~clk;

    dmem_line_responder #(.LATENCY(Lat), .DEPTH_LOG2(DLog)) u_dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .write_i(wr), .addr_i(addr),
        .data_i(din), .ack_o(ack), .data_o(dout)
    );

    dmem_line_responder #(.LATENCY(1), .DEPTH_LOG2(DLog)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en1), .write_i(wr1), .addr_i(addr1),
        .data_i(din1), .ack_o(ack1), .data_o(dout1)
    );

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32) % Lines);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on the LATENCY=10 instance; checks ack timing, data and model.
    task automatic req10(input bit w, input logic [31:0] a, input logic [255:0] d,
                         input bit noise, input string tag);
        int lat;
        int li;
        li = line_of(a);
        @(negedge clk);
        en = 1'b1; wr = w; addr = a; din = d;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (noise) begin
                addr = $urandom;
                din  = rand_line();
            end
            @(posedge clk);
            #1;
            if (ack === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, " ack latency"}, 256'(lat), 256'(Lat));
        if (lat > 0) begin
            if (w) begin
                check({tag, " data_o held on write"}, dout, last_rd);
                model[li] = d;
                known[li] = 1'b1;
            end else begin
                if (known[li]) check({tag, " read data"}, dout, model[li]);
                last_rd = model[li];
            end
        end
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " ack single cycle"}, 256'(ack), 256'(0));
    endtask

    initial begin
        logic [255:0] old_d, new_d, pat;
        logic [31:0]  a;
        int           li;

        rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; din = '0;
        en1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
        last_rd = '0;
        for (int i = 0; i < Lines; i++) known[i] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            check("idle ack", 256'(ack), 256'(0));
        end
        check("idle data_o", dout, 256'(0));

        // Basic write then read
        req10(1'b1, 32'h0000_0040, {8{32'hDEAD_BEEF}}, 1'b0, "write 0x40");
        req10(1'b0, 32'h0000_0040, 256'(0), 1'b0, "read 0x40");
        check("read 0x40 literal", dout, {8{32'hDEAD_BEEF}});

        // Aliasing: offset bits and high bits ignored
        pat = rand_line();
        req10(1'b1, 32'h0000_0043, pat, 1'b0, "alias write");
        req10(1'b0, 32'h0000_4040, 256'(0), 1'b0, "alias read");
        check("alias literal", dout, pat);

        // Inputs scrambled during the wait
        pat = rand_line();
        req10(1'b1, 32'h0000_0100, pat, 1'b1, "noisy write");
        req10(1'b0, 32'h0000_0100, 256'(0), 1'b1, "noisy read");

        // Reset mid-write drops the write
        old_d = rand_line();
        new_d = ~old_d;
        req10(1'b1, 32'h0000_0080, old_d, 1'b0, "w80 old");
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 32'h0000_0080; din = new_d;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset ack", 256'(ack), 256'(0));
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            check("post-reset ack", 256'(ack), 256'(0));
        end
        check("post-reset data_o", dout, 256'(0));
        last_rd = '0;
        req10(1'b0, 32'h0000_0080, 256'(0), 1'b0, "r80 after reset");
        check("r80 old literal", dout, old_d);

        // Randomized traffic over a handful of lines with aliased addresses
        for (int i = 0; i < 8; i++) begin
            li = $urandom_range(0, Lines - 1);
            idx_q.push_back(li);
            a = ($urandom & 32'hFFFF_C000) | (li << 5) | $urandom_range(0, 31);
            req10(1'b1, a, rand_line(), $urandom_range(0, 1), "rand fill");
        end
        for (int i = 0; i < 24; i++) begin
            li = idx_q[$urandom_range(0, idx_q.size() - 1)];
            a = ($urandom & 32'hFFFF_C000) | (li << 5) | $urandom_range(0, 31);
            req10(1'(($urandom_range(0, 2)) == 0), a, rand_line(), $urandom_range(0, 1),
                  "rand op");
        end

        // LATENCY=1 with enable held: acks every LATENCY+2 cycles
        pat = rand_line();
        @(negedge clk);
        en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0000_1000; din1 = pat;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat1 ack T+%0d", k), 256'(ack1), 256'((k % 3) == 1));
        end
        @(negedge clk);
        en1 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0000_1000;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("lat1 read ack", 256'(ack1), 256'(1));
        check("lat1 read data", dout1, pat);
        @(negedge clk);
        en1 = 1'b0;
        @(posedge clk);
        #1;
        check("lat1 bubble", 256'(ack1), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
